dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port data-memory arbiter (MEM stage vs external loader).
//               Fixed CPU priority, lockable external bursts, and an optional
//               ext starvation guard enabled by DMEM_ARB_STARVE_GUARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              ext_rd,
    input  logic              ext_wr,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    input  logic              ext_lock,
    output logic              cpu_gnt,
    output logic              ext_gnt,
    output logic              cpu_stall,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [DATA_W-1:0] ext_rdata,
    output logic [1:0]        owner
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_CPU      = 2'd1;
    localparam logic [1:0] c_EXT      = 2'd2;
    localparam logic [1:0] c_EXT_LOCK = 2'd3;

    generate
        if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_limitCheck
            $error("dmem_arbiter: STARVE_LIMIT must be within 1..255");
        end
    endgenerate

    logic [1:0] r_owner;
    logic [1:0] w_nextOwner;
    logic       w_cpuReq;
    logic       w_extReq;
    logic       w_cpuGnt;
    logic       w_extGnt;
    logic       w_forceExt;

    assign w_cpuReq = cpu_rd | cpu_wr;
    assign w_extReq = ext_rd | ext_wr;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam logic [7:0] c_STARVE_LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] r_waitCnt;

    assign w_forceExt = w_extReq && (r_waitCnt == c_STARVE_LIMIT);

    // Counts consecutive denied ext cycles; saturates so the force stays armed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_waitCnt <= 8'd0;
        end else if (w_extGnt || !w_extReq) begin
            r_waitCnt <= 8'd0;
        end else if (r_waitCnt < c_STARVE_LIMIT) begin
            r_waitCnt <= r_waitCnt + 8'd1;
        end
    end
`else
    assign w_forceExt = 1'b0;
`endif

    // Grants are gated by reset so every output reads zero while it is held
    always_comb begin
        w_cpuGnt = 1'b0;
        w_extGnt = 1'b0;
        if (!reset) begin
            if (r_owner == c_EXT_LOCK) begin
                w_extGnt = w_extReq;
            end else if (w_forceExt) begin
                w_extGnt = 1'b1;
            end else if (w_cpuReq) begin
                w_cpuGnt = 1'b1;
            end else begin
                w_extGnt = w_extReq;
            end
        end
    end

    always_comb begin
        w_nextOwner = c_IDLE;
        if (r_owner == c_EXT_LOCK) begin
            w_nextOwner = (w_extReq && ext_lock) ? c_EXT_LOCK : c_IDLE;
        end else if (w_extGnt) begin
            w_nextOwner = ext_lock ? c_EXT_LOCK : c_EXT;
        end else if (w_cpuGnt) begin
            w_nextOwner = c_CPU;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner <= c_IDLE;
        end else begin
            r_owner <= w_nextOwner;
        end
    end

    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_cpuGnt) begin
            mem_rd    = cpu_rd;
            mem_wr    = cpu_wr;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (w_extGnt) begin
            mem_rd    = ext_rd;
            mem_wr    = ext_wr;
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
        end
    end

    assign cpu_gnt   = w_cpuGnt;
    assign ext_gnt   = w_extGnt;
    assign cpu_stall = w_cpuReq & ~w_cpuGnt & ~reset;
    assign cpu_rdata = w_cpuGnt ? mem_rdata : '0;
    assign ext_rdata = w_extGnt ? mem_rdata : '0;
    assign owner     = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter with a request-level
//               arbitration model, a shadow memory and directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int STARVE_LIMIT = 8;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_rd, cpu_wr, ext_rd, ext_wr, ext_lock;
    logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
    logic        cpu_gnt, ext_gnt, cpu_stall, mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, cpu_rdata, ext_rdata;
    logic [1:0]  owner;

    logic [31:0] mem    [64];
    logic [31:0] shadow [64];

    int checks = 0;
    int errors = 0;
    bit compareEn = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .ext_rd(ext_rd), .ext_wr(ext_wr), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_lock(ext_lock),
        .cpu_gnt(cpu_gnt), .ext_gnt(ext_gnt), .cpu_stall(cpu_stall),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .cpu_rdata(cpu_rdata), .ext_rdata(ext_rdata),
        .owner(owner)
    );

    // Memory seen by the DUT: combinational read, commit on the clock edge
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr[7:2]] <= mem_wdata;
    end

    function automatic logic [31:0] memInit(int i);
        if (i == 4) return 32'hDEADBEEF;
        return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner as a plain number, ext waiting time as a plain counter
    int mOwner  = 0;
    int mDenied = 0;

    function automatic void expGrants(output bit eC, output bit eE);
        bit cr, er;
        cr = cpu_rd | cpu_wr;
        er = ext_rd | ext_wr;
        eC = 1'b0;
        eE = 1'b0;
        if (reset) return;
        if (mOwner == 3)                                   eE = er;
        else if (GUARD && er && mDenied >= STARVE_LIMIT)   eE = 1'b1;
        else if (cr)                                       eC = 1'b1;
        else                                               eE = er;
    endfunction

    always @(posedge clk or posedge reset) begin
        bit eC, eE, er;
        if (reset) begin
            mOwner  = 0;
            mDenied = 0;
        end else begin
            expGrants(eC, eE);
            er = ext_rd | ext_wr;
            if (eC && cpu_wr) shadow[cpu_addr[7:2]] = cpu_wdata;
            if (eE && ext_wr) shadow[ext_addr[7:2]] = ext_wdata;
            if (eE || !er)                  mDenied = 0;
            else if (mDenied < STARVE_LIMIT) mDenied = mDenied + 1;
            if (mOwner == 3)  mOwner = (er && ext_lock) ? 3 : 0;
            else if (eE)      mOwner = ext_lock ? 3 : 2;
            else if (eC)      mOwner = 1;
            else              mOwner = 0;
        end
    end

    bit          cC, cE;
    logic [31:0] cAddr, cWdata;
    logic        cRd, cWr;

    always @(negedge clk) begin
        if (compareEn) begin
            expGrants(cC, cE);
            cRd    = cC ? cpu_rd    : cE ? ext_rd    : 1'b0;
            cWr    = cC ? cpu_wr    : cE ? ext_wr    : 1'b0;
            cAddr  = cC ? cpu_addr  : cE ? ext_addr  : 32'h0;
            cWdata = cC ? cpu_wdata : cE ? ext_wdata : 32'h0;
            check("cpu_gnt",   64'(cpu_gnt),   64'(cC));
            check("ext_gnt",   64'(ext_gnt),   64'(cE));
            check("cpu_stall", 64'(cpu_stall), 64'((cpu_rd | cpu_wr) && !cC && !reset));
            check("owner",     64'(owner),     64'(mOwner));
            check("mem_rd",    64'(mem_rd),    64'(cRd));
            check("mem_wr",    64'(mem_wr),    64'(cWr));
            check("mem_addr",  64'(mem_addr),  64'(cAddr));
            check("mem_wdata", 64'(mem_wdata), 64'(cWdata));
            check("cpu_rdata", 64'(cpu_rdata), cC ? 64'(shadow[cAddr[7:2]]) : 64'h0);
            check("ext_rdata", 64'(ext_rdata), cE ? 64'(shadow[cAddr[7:2]]) : 64'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearReqs();
        cpu_rd = 0; cpu_wr = 0; ext_rd = 0; ext_wr = 0; ext_lock = 0;
        cpu_addr = 0; cpu_wdata = 0; ext_addr = 0; ext_wdata = 0;
    endtask

    initial begin
        int nMis;
        for (int i = 0; i < 64; i++) begin
            mem[i]    = memInit(i);
            shadow[i] = memInit(i);
        end
        clearReqs();
        reset = 1'b1;
        cpu_rd = 1; cpu_addr = 32'h10;
        compareEn = 1'b1;
        tick();
        tick();
        // Requests during reset must be ignored
        check("rst_owner", 64'(owner), 64'd0);
        check("rst_cpu_gnt", 64'(cpu_gnt), 64'd0);
        check("rst_stall", 64'(cpu_stall), 64'd0);
        check("rst_mem_rd", 64'(mem_rd), 64'd0);
        check("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
        reset = 1'b0;
        clearReqs();

        repeat (5) tick();
        check("idle_owner", 64'(owner), 64'd0);
        check("idle_mem_rdwr", 64'({mem_rd, mem_wr}), 64'd0);
        check("idle_rdata", 64'({cpu_rdata, ext_rdata}), 64'd0);

        cpu_rd = 1; cpu_addr = 32'h10;
        @(negedge clk); #1;
        check("rd_cpu_gnt", 64'(cpu_gnt), 64'd1);
        check("rd_cpu_rdata", 64'(cpu_rdata), 64'hDEADBEEF);
        check("rd_cpu_stall", 64'(cpu_stall), 64'd0);
        tick();

        cpu_rd = 0; cpu_wr = 1; cpu_addr = 32'h20; cpu_wdata = 32'h12345678;
        tick();
        cpu_wr = 0; cpu_rd = 1;
        @(negedge clk); #1;
        check("wr_readback", 64'(cpu_rdata), 64'h12345678);
        tick();

        clearReqs();
        ext_wr = 1; ext_addr = 32'h30; ext_wdata = 32'hA5A5_0030;
        @(negedge clk); #1;
        check("ext_zero_lat", 64'(ext_gnt), 64'd1);
        tick();
        clearReqs();
        tick();

        // Contention: both ports write and hold their requests
        cpu_wr = 1; cpu_addr = 32'h40; cpu_wdata = 32'hC1C1_0040;
        ext_wr = 1; ext_addr = 32'h44; ext_wdata = 32'hE1E1_0044;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check($sformatf("starve_ext_c%0d", k), 64'(ext_gnt), 64'(GUARD && k == 9));
            check($sformatf("starve_cpu_c%0d", k), 64'(cpu_gnt), 64'(!(GUARD && k == 9)));
            tick();
        end
        clearReqs();
        tick();

        // Locked ext burst with a cpu read arriving in its second cycle
        for (int k = 1; k <= 6; k++) begin
            ext_wr   = (k <= 4);
            ext_lock = (k <= 4);
            ext_addr = 32'h50 + 32'(k);
            ext_wdata = 32'hB0B0_0000 + 32'(k);
            cpu_rd   = (k >= 2);
            cpu_addr = 32'h10;
            @(negedge clk);
            check($sformatf("lock_ext_c%0d", k), 64'(ext_gnt), 64'(k <= 4));
            check($sformatf("lock_stall_c%0d", k), 64'(cpu_stall), 64'(k >= 2 && k <= 5));
            check($sformatf("lock_cpu_c%0d", k), 64'(cpu_gnt), 64'(k == 6));
            check($sformatf("lock_owner_c%0d", k), 64'(owner), (k >= 2 && k <= 5) ? 64'd3 : 64'd0);
            tick();
        end
        clearReqs();
        tick();

        // Asynchronous reset in the middle of a locked write burst
        ext_wr = 1; ext_lock = 1; ext_addr = 32'h60; ext_wdata = 32'hBAD0BAD0;
        tick();
        ext_addr = 32'h64; ext_wdata = 32'hCAFEF00D;
        #1;
        check("burst_owner", 64'(owner), 64'd3);
        #1;
        reset = 1'b1;
        #1;
        check("arst_owner", 64'(owner), 64'd0);
        check("arst_grants", 64'({cpu_gnt, ext_gnt}), 64'd0);
        check("arst_mem_wr", 64'(mem_wr), 64'd0);
        tick();
        check("arst_no_commit", 64'(mem[25]), 64'(memInit(25)));
        clearReqs();
        reset = 1'b0;
        cpu_rd = 1; cpu_addr = 32'h60;
        @(negedge clk); #1;
        check("post_rst_owner", 64'(owner), 64'd0);
        check("post_rst_cpu_gnt", 64'(cpu_gnt), 64'd1);
        check("post_rst_rdata", 64'(cpu_rdata), 64'hBAD0BAD0);
        tick();
        clearReqs();
        repeat (2) tick();

        compareEn = 1'b0;
        nMis = 0;
        for (int i = 0; i < 64; i++) begin
            if (mem[i] !== shadow[i]) nMis++;
        end
        check("mem_image", 64'(nMis), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
